// File: rtl/bright_pkg.sv
// Shared types for the brightness/contrast pipe: mode encoding and the shadowed config word.
// Config fields are held at a fixed 16-bit width (offset sign-extended, gain zero-extended).
package bright_pkg;

  localparam int BC_CFG_W     = 16;
  localparam int BC_GAIN_FRAC = 4;
  localparam logic [BC_CFG_W-1:0] GAIN_ONE = BC_CFG_W'(1) << BC_GAIN_FRAC;

  typedef enum logic [1:0] {
    BC_BYPASS   = 2'b00,
    BC_OFS      = 2'b01,
    BC_GAIN     = 2'b10,
    BC_GAIN_OFS = 2'b11
  } bc_mode_t;

  typedef struct packed {
    bc_mode_t              mode;
    logic [BC_CFG_W-1:0]   offset;
    logic [BC_CFG_W-1:0]   gain;
  } bc_cfg_t;

  function automatic logic is_gain(input bc_mode_t m);
    return (m == BC_GAIN) || (m == BC_GAIN_OFS);
  endfunction

  function automatic logic is_ofs(input bc_mode_t m);
    return (m == BC_OFS) || (m == BC_GAIN_OFS);
  endfunction

endpackage

// File: rtl/bc_chan_alu.sv
// One channel of the pipe: stage1 rounded gain, stage2 offset + saturate; 2 registered stages.
// Both stages hold while en=0; clip flags (BRIGHT_SAT_CNT_EN) are registered alongside q.
module bc_chan_alu
  import bright_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int GAIN_FRAC = BC_GAIN_FRAC
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  bc_mode_t            mode,
  input  logic [BC_CFG_W-1:0] gain,
  input  logic [DATA_W-1:0]   d,
  input  bc_mode_t            s1_mode,
  input  logic [BC_CFG_W-1:0] s1_ofs,
`ifdef BRIGHT_SAT_CNT_EN
  output logic                sat_hi,
  output logic                sat_lo,
`endif
  output logic [DATA_W-1:0]   q
);

  localparam int P_W = DATA_W + BC_CFG_W;
  localparam int S_W = P_W + BC_CFG_W + 1;
  localparam logic [P_W-1:0] HALF = P_W'(1) << (GAIN_FRAC - 1);

  logic [P_W-1:0]        prod, p_nxt, p1;
  logic signed [S_W-1:0] s;
  logic                  hi, lo;
  logic [DATA_W-1:0]     q_nxt;

  always_comb begin
    prod  = P_W'(d) * P_W'(gain) + HALF;
    p_nxt = is_gain(mode) ? (prod >> GAIN_FRAC) : P_W'(d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   p1 <= '0;
    else if (en) p1 <= p_nxt;
  end

  // s is wide enough that neither the add nor the sign can overflow
  always_comb begin
    s = $signed(S_W'(p1));
    if (is_ofs(s1_mode)) s = s + S_W'($signed(s1_ofs));
    lo    = s[S_W-1];
    hi    = !s[S_W-1] && (|s[S_W-2:DATA_W]);
    q_nxt = hi ? '1 : (lo ? '0 : s[DATA_W-1:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= q_nxt;
  end

`ifdef BRIGHT_SAT_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_hi <= 1'b0;
      sat_lo <= 1'b0;
    end else if (en) begin
      sat_hi <= hi;
      sat_lo <= lo;
    end
  end
`endif

endmodule

// File: rtl/bright_contrast_pipe.sv
// Per-pixel brightness/contrast, 2-cycle latency, 1 beat/cycle; all stages stall when out_valid && !out_ready.
// Config is shadowed on accepted sof beats; BRIGHT_SAT_CNT_EN adds per-frame clip counters.
module bright_contrast_pipe
  import bright_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_CH    = 3,
  parameter int OFS_W     = 9,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = BC_GAIN_FRAC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               cfg_mode,
  input  logic [OFS_W-1:0]         cfg_offset,
  input  logic [GAIN_W-1:0]        cfg_gain,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sof,
  input  logic                     in_eol,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sof,
  output logic                     out_eol,
  output logic [NUM_CH*DATA_W-1:0] out_data
`ifdef BRIGHT_SAT_CNT_EN
  ,
  output logic [15:0]              sat_hi_cnt,
  output logic [15:0]              sat_lo_cnt
`endif
);

  localparam logic [BC_CFG_W-1:0] GAIN_RST = BC_CFG_W'(1) << GAIN_FRAC;

  logic                adv, sof_take;
  bc_cfg_t             shadow, eff;
  logic                s1_vld, s1_sof, s1_eol;
  bc_mode_t            s1_mode;
  logic [BC_CFG_W-1:0] s1_ofs;
  logic [DATA_W-1:0]   ch_q [NUM_CH];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign sof_take = in_valid && adv && in_sof;

  // an sof beat uses the live config directly, so it sees the values it loads
  always_comb begin
    eff = shadow;
    if (in_sof) begin
      eff.mode   = bc_mode_t'(cfg_mode);
      eff.offset = BC_CFG_W'($signed(cfg_offset));
      eff.gain   = BC_CFG_W'(cfg_gain);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         shadow <= '{mode: BC_BYPASS, offset: '0, gain: GAIN_RST};
    else if (sof_take) shadow <= eff;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld    <= 1'b0;
      s1_sof    <= 1'b0;
      s1_eol    <= 1'b0;
      s1_mode   <= BC_BYPASS;
      s1_ofs    <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (adv) begin
      s1_vld    <= in_valid;
      s1_sof    <= in_sof;
      s1_eol    <= in_eol;
      s1_mode   <= eff.mode;
      s1_ofs    <= eff.offset;
      out_valid <= s1_vld;
      out_sof   <= s1_sof;
      out_eol   <= s1_eol;
    end
  end

`ifdef BRIGHT_SAT_CNT_EN
  logic ch_hi [NUM_CH];
  logic ch_lo [NUM_CH];
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    bc_chan_alu #(.DATA_W(DATA_W), .GAIN_FRAC(GAIN_FRAC)) u_alu (
      .clk     (clk),
      .reset   (reset),
      .en      (adv),
      .mode    (eff.mode),
      .gain    (eff.gain),
      .d       (in_data[c*DATA_W +: DATA_W]),
      .s1_mode (s1_mode),
      .s1_ofs  (s1_ofs),
`ifdef BRIGHT_SAT_CNT_EN
      .sat_hi  (ch_hi[c]),
      .sat_lo  (ch_lo[c]),
`endif
      .q       (ch_q[c])
    );
  end

  always_comb begin
    out_data = '0;
    for (int c = 0; c < NUM_CH; c++) out_data[c*DATA_W +: DATA_W] = ch_q[c];
  end

`ifdef BRIGHT_SAT_CNT_EN
  logic any_hi, any_lo, out_xfer;

  always_comb begin
    any_hi = 1'b0;
    any_lo = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      any_hi = any_hi | ch_hi[c];
      any_lo = any_lo | ch_lo[c];
    end
  end

  assign out_xfer = out_valid && out_ready;

  // an sof beat restarts the count, including its own clip
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_hi_cnt <= '0;
      sat_lo_cnt <= '0;
    end else if (out_xfer) begin
      if (out_sof) begin
        sat_hi_cnt <= {15'd0, any_hi};
        sat_lo_cnt <= {15'd0, any_lo};
      end else begin
        if (any_hi && (sat_hi_cnt != 16'hFFFF)) sat_hi_cnt <= sat_hi_cnt + 16'd1;
        if (any_lo && (sat_lo_cnt != 16'hFFFF)) sat_lo_cnt <= sat_lo_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
